push_debounce: RTL and testbench

Multi-channel push-button conditioning stage placed directly upstream of the answer-entry counters and step comparators. Each raw button input is synchronised to `clk`, filtered by a stability counter, and converted into a debounced level plus a single-cycle press pulse. The press pulse drives the counters' increment input. This replaces the single-flop edge detector, which passes contact bounce through as multiple counts.

---
 rtl/push_debounce_pkg.sv | 16 +
 rtl/debounce_channel.sv | 162 ++++++++++++++++
 rtl/push_debounce.sv | 37 +++
 tb/tb_push_debounce.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/push_debounce_pkg.sv
// push_debounce_pkg: shared state encoding and default timing constants
// for the push-button debounce block.
package push_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam int DEF_STABLE_CYC = 50000;
    localparam int DEF_REPEAT_DLY = 25000000;
    localparam int DEF_REPEAT_PER = 10000000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button channel -- two-flop synchroniser, stability
// FSM and shared filter/repeat counter. Produces a debounced level plus
// registered one-cycle press (pulse) and release (rel) strobes.
// Optional auto-repeat while held is compiled in with PUSH_DEBOUNCE_REPEAT_EN.
module debounce_channel
    import push_debounce_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int REPEAT_PER = DEF_REPEAT_PER
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    output logic level,
    output logic pulse,
    output logic rel
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_T = CNT_W'(STABLE_CYC);
`ifdef PUSH_DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_T    = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] RELOAD_T = CNT_W'(REPEAT_DLY - REPEAT_PER);
`endif

    // Parameter legality is checked at elaboration; the counter never wraps.
    if (STABLE_CYC < 1 || STABLE_CYC > (2 ** CNT_W) - 1) begin : g_bad_stable
        $error("debounce_channel: STABLE_CYC out of range for CNT_W");
    end
    if (REPEAT_PER < 1 || REPEAT_PER > REPEAT_DLY) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_PER must be in 1..REPEAT_DLY");
    end
`ifdef PUSH_DEBOUNCE_REPEAT_EN
    if (REPEAT_DLY > (2 ** CNT_W) - 1) begin : g_bad_dly
        $error("debounce_channel: REPEAT_DLY out of range for CNT_W");
    end
`endif

    logic             s1;
    logic             s2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             pulse_nxt;
    logic             rel_nxt;

    assign cnt_inc = cnt + ONE;
    assign level   = (state == HELD) || (state == RELEASE_WAIT);

    // Synchroniser, FSM state, counter and strobe registers; reset clears all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= push;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            rel   <= rel_nxt;
        end
    end

    // Next state and counter: a level change is accepted only after
    // STABLE_CYC consecutive agreeing samples; any disagreement aborts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (s2) begin
                    if (STABLE_T == ONE) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_inc == STABLE_T) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            HELD: begin
                if (!s2) begin
                    if (STABLE_T == ONE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = ONE;
                    end
                end else begin
`ifdef PUSH_DEBOUNCE_REPEAT_EN
                    // Hold timer: reload after each repeat so the next one
                    // lands REPEAT_PER cycles later.
                    if (cnt_inc == DLY_T) cnt_nxt = RELOAD_T;
                    else                  cnt_nxt = cnt_inc;
`else
                    cnt_nxt = '0;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    // Release glitch: back to held, hold timer restarts at 0.
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt_inc == STABLE_T) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Strobe decode: fire on the edge that accepts a press/release
    // (and, with repeat, on each hold-timer expiry).
    always_comb begin
        pulse_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            IDLE:         pulse_nxt = s2 && (STABLE_T == ONE);
            PRESS_WAIT:   pulse_nxt = s2 && (cnt_inc == STABLE_T);
            HELD: begin
                rel_nxt = !s2 && (STABLE_T == ONE);
`ifdef PUSH_DEBOUNCE_REPEAT_EN
                pulse_nxt = s2 && (cnt_inc == DLY_T);
`endif
            end
            RELEASE_WAIT: rel_nxt = !s2 && (cnt_inc == STABLE_T);
            default: begin
                pulse_nxt = 1'b0;
                rel_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/push_debounce.sv
// push_debounce: N_BTN independent debounce channels for raw push buttons.
// Each channel yields a debounced level and one-cycle press/release strobes.
// Define PUSH_DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while held.
module push_debounce
    import push_debounce_pkg::*;
#(
    parameter int N_BTN      = 14,
    parameter int CNT_W      = 16,
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int REPEAT_PER = DEF_REPEAT_PER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] push,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] pulse,
    output logic [N_BTN-1:0] rel
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .CNT_W      (CNT_W),
            .STABLE_CYC (STABLE_CYC),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .level (level[i]),
            .pulse (pulse[i]),
            .rel   (rel[i])
        );
    end

endmodule

// File: tb/tb_push_debounce.sv
// tb_push_debounce: directed scenarios plus randomized traffic, checked
// cycle by cycle against a run-length reference model of the debouncer.
module tb_push_debounce;

    localparam int N   = 14;
    localparam int STB = 4;
    localparam int DLY = 10;
    localparam int PER = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] push;
    logic [N-1:0] level;
    logic [N-1:0] pulse;
    logic [N-1:0] rel;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit d1[N];
    bit d2[N];
    bit lv[N];
    int run[N];
    int hold[N];
    logic [N-1:0] m_level, m_pulse, m_rel;

    push_debounce #(
        .N_BTN      (N),
        .CNT_W      (8),
        .STABLE_CYC (STB),
        .REPEAT_DLY (DLY),
        .REPEAT_PER (PER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .level (level),
        .pulse (pulse),
        .rel   (rel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            d1[c] = 0; d2[c] = 0; lv[c] = 0; run[c] = 0; hold[c] = 0;
        end
        m_level = '0; m_pulse = '0; m_rel = '0;
    endtask

    // One clock edge of the model: the filter sees the input two samples late;
    // a change is accepted when the delayed input has disagreed with the
    // debounced level for STB consecutive samples.
    task automatic model_edge(input logic [N-1:0] p);
        for (int c = 0; c < N; c++) begin
            bit d;
            d = d2[c];
            d2[c] = d1[c];
            d1[c] = p[c];
            m_pulse[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (d != lv[c]) begin
                run[c]++;
                if (run[c] == STB) begin
                    lv[c] = d;
                    run[c] = 0;
                    hold[c] = 0;
                    if (d) m_pulse[c] = 1'b1;
                    else   m_rel[c]   = 1'b1;
                end
            end else begin
                if (lv[c]) begin
                    if (run[c] != 0) hold[c] = 0;
                    else begin
                        hold[c]++;
`ifdef PUSH_DEBOUNCE_REPEAT_EN
                        if (hold[c] == DLY) begin
                            m_pulse[c] = 1'b1;
                            hold[c] = DLY - PER;
                        end
`endif
                    end
                end
                run[c] = 0;
            end
            m_level[c] = lv[c];
        end
    endtask

    // Drive one sample, advance one clock, compare against the model.
    task automatic step(input logic [N-1:0] p);
        push = p;
        @(posedge clk);
        model_edge(p);
        @(negedge clk);
        check("level", 32'(level), 32'(m_level));
        check("pulse", 32'(pulse), 32'(m_pulse));
        check("rel",   32'(rel),   32'(m_rel));
    endtask

    task automatic async_reset_check(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_pulse"}, 32'(pulse), 32'd0);
        check({tag, "_rel"},   32'(rel),   32'd0);
    endtask

    initial begin
        int np, nr, fp, fr, np_other;
        logic lmin;
        logic [N-1:0] cur;

        push  = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_pulse", 32'(pulse), 32'd0);
        check("rst_rel",   32'(rel),   32'd0);
        reset = 1'b1;
        repeat (3) step('0);

        // Clean press on channel 0, then release
        np = 0; fp = -1;
        for (int i = 0; i < 12; i++) begin
            step(14'h0001);
            if (pulse[0]) begin np++; if (fp < 0) fp = i; end
            if (i == 5) check("clean_level_at5", 32'(level[0]), 32'd1);
            if (i == 4) check("clean_level_at4", 32'(level[0]), 32'd0);
        end
        check("clean_npulse", np, 1);
        check("clean_pulse_edge", fp, 5);
        nr = 0; fr = -1;
        for (int i = 0; i < 10; i++) begin
            step('0);
            if (rel[0]) begin nr++; if (fr < 0) fr = i; end
        end
        check("clean_nrel", nr, 1);
        check("clean_rel_edge", fr, 5);

        // Bounce on channel 3: 1,1,0,1,1,1,0 then steady 1
        begin
            logic [6:0] pat;
            pat = 7'b0111011; // bit k = sample k
            np = 0; fp = -1;
            for (int i = 0; i < 17; i++) begin
                logic b;
                b = (i < 7) ? pat[i] : 1'b1;
                step(14'(b) << 3);
                if (pulse[3]) begin np++; if (fp < 0) fp = i; end
            end
            check("bounce_npulse", np, 1);
            check("bounce_pulse_edge", fp, 12);
        end
        repeat (10) step('0);

        // Simultaneous press on channels 0 and 13
        np = 0; nr = 0; np_other = 0;
        for (int i = 0; i < 8; i++) begin
            step(14'h2001);
            if (pulse[0] && pulse[13]) np++;
            if (pulse[0] != pulse[13]) nr++;
            if ((pulse & ~14'h2001) != '0) np_other++;
        end
        check("simul_both", np, 1);
        check("simul_split", nr, 0);
        check("simul_others", np_other, 0);
        repeat (10) step('0);

        // Reset in the middle of the press filter on channel 0
        for (int i = 0; i < 4; i++) step(14'h0001);
        async_reset_check("midrst");
        repeat (2) begin
            @(negedge clk);
            check("midrst_hold_pulse", 32'(pulse), 32'd0);
        end
        reset = 1'b1;
        np = 0; fp = -1;
        for (int i = 0; i < 8; i++) begin
            step(14'h0001);
            if (pulse[0]) begin np++; if (fp < 0) fp = i; end
        end
        check("midrst_npulse", np, 1);
        check("midrst_pulse_edge", fp, STB + 1);

        // Release glitch while held on channel 0
        np = 0; nr = 0; lmin = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step((i < 2) ? 14'h0000 : 14'h0001);
            if (pulse[0]) np++;
            if (rel[0]) nr++;
            lmin = lmin & level[0];
        end
        check("glitch_npulse", np, 0);
        check("glitch_nrel", nr, 0);
        check("glitch_level", 32'(lmin), 32'd1);
        repeat (10) step('0);

        // Long hold on channel 1: auto-repeat count
        np = 0;
        for (int i = 0; i < 32; i++) begin
            step(14'h0002);
            if (pulse[1]) np++;
        end
`ifdef PUSH_DEBOUNCE_REPEAT_EN
        check("hold_npulse", np, 5);
`else
        check("hold_npulse", np, 1);
`endif
        repeat (10) step('0);

        // Randomized traffic with one asynchronous reset in the middle
        cur = '0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
            if (i == 400) begin
                async_reset_check("rndrst");
                @(negedge clk);
                reset = 1'b1;
            end
            step(cur);
            check("pulse_rel_excl", 32'(pulse & rel), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
